spi_slave_param: RTL

Parameterised next-generation SPI slave front end, sampled on the system clock; SS_n frames the transaction.
- Receives a (2+DATA_W)-bit frame MSB-first: 2-bit command followed by a DATA_W-bit payload.
- Presents the frame on rx_data with a one-cycle rx_valid strobe.
- For read-data commands, waits for tx_data/tx_valid from the memory side and shifts DATA_W bits out on MISO.
- Adds abort/error detection and a response timeout.
- Sits between the SPI pins and the RAM controller.

---
 rtl/spi_slave_param.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_param.sv
// SPI slave front end sampled on the system clock: receives {cmd, payload} frames
// and shifts a read-data response word out on MISO for read-data commands.
module spi_slave_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned CNT_MAX = (TX_TIMEOUT > DATA_W) ? TX_TIMEOUT : DATA_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    SEND,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W:0]    rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               miso_q, miso_d;

  // Frame as it will look once the bit currently on MOSI is taken as bit 0
  logic [FRAME_W-1:0] frame_c;
  logic [1:0]         cmd_c;
  logic               last_bit_c;
  logic               illegal_c;
  logic               timeout_c;
  logic               send_last_c;

  assign frame_c     = {rx_shift_q, MOSI};
  assign cmd_c       = frame_c[FRAME_W-1 -: 2];
  assign last_bit_c  = (cnt_q == '0);
  assign illegal_c   = ((cmd_c == 2'b11) && !rd_addr_seen_q) ||
                       ((state_q != WRITE) && !cmd_c[1]);
  assign timeout_c   = (cnt_q == CNT_W'(TX_TIMEOUT - 1));
  assign send_last_c = (cnt_q == CNT_W'(DATA_W - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      cnt_q          <= '0;
      rd_addr_seen_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      cnt_q          <= cnt_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
      miso_q         <= miso_d;
    end
  end

  // Next state; SS_n high pulls every active state back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!SS_n) state_d = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)                state_d = IDLE;
        else if (!MOSI)          state_d = WRITE;
        else if (rd_addr_seen_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n)            state_d = IDLE;
        else if (last_bit_c) state_d = (!illegal_c && (cmd_c == 2'b11)) ? WAIT_TX : DONE;
      end
      WAIT_TX: begin
        if (SS_n)           state_d = IDLE;
        else if (tx_valid)  state_d = SEND;
        else if (timeout_c) state_d = DONE;
      end
      SEND: begin
        if (SS_n)             state_d = IDLE;
        else if (send_last_c) state_d = DONE;
      end
      DONE:    if (SS_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; MISO defaults low outside SEND
  always_comb begin
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    cnt_d          = cnt_q;
    rd_addr_seen_d = rd_addr_seen_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    miso_d         = 1'b0;
    case (state_q)
      CHK_CMD: begin
        if (SS_n) begin
          frame_err_d = 1'b1;
        end else begin
          rx_shift_d = {{DATA_W{1'b0}}, MOSI};
          cnt_d      = CNT_W'(DATA_W);
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          frame_err_d = 1'b1;
        end else if (last_bit_c) begin
          cnt_d = '0;
          if (illegal_c) begin
            frame_err_d = 1'b1;
          end else begin
            rx_data_d  = frame_c;
            rx_valid_d = 1'b1;
            if (cmd_c == 2'b10)      rd_addr_seen_d = 1'b1;
            else if (cmd_c == 2'b11) rd_addr_seen_d = 1'b0;
          end
        end else begin
          rx_shift_d = {rx_shift_q[DATA_W-1:0], MOSI};
          cnt_d      = cnt_q - CNT_W'(1);
        end
      end
      WAIT_TX: begin
        if (!SS_n) begin
          if (tx_valid) begin
            miso_d     = tx_data[DATA_W-1];
            tx_shift_d = tx_data << 1;
            cnt_d      = '0;
          end else if (timeout_c) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SEND: begin
        if (!SS_n && !send_last_c) begin
          miso_d     = tx_shift_q[DATA_W-1];
          tx_shift_d = tx_shift_q << 1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule
